// File: rtl/demux_2x1_flop_if.sv
// Bus between the 2x1 mux stage output and the demux: tagged word stream in,
// recovered lane pair plus status counters out.
interface demux_2x1_flop_if #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned CNT_W = 4
);
   logic             valid_in;
   logic             selector_in;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out_0;
   logic [WIDTH-1:0] data_out_1;
   logic             valid_out;
   logic             error_out;
   logic [CNT_W-1:0] pair_count;
   logic [CNT_W-1:0] error_count;

   modport master (
      output valid_in, selector_in, data_in,
      input  data_out_0, data_out_1, valid_out, error_out, pair_count, error_count
   );

   modport slave (
      input  valid_in, selector_in, data_in,
      output data_out_0, data_out_1, valid_out, error_out, pair_count, error_count
   );
endinterface

// File: rtl/demux_2x1_flop.sv
// Registered 1-to-2 demux: rebuilds lane 0/lane 1 pairs from a tagged word stream,
// flags lane-order faults and resynchronises on them.
module demux_2x1_flop #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned CNT_W = 4
) (
   input logic               clk,
   input logic               reset,
   demux_2x1_flop_if.slave   bus
);

   typedef enum logic {
      WAIT_0 = 1'b0,
      WAIT_1 = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hold0_q, hold0_d;
   logic [WIDTH-1:0] data0_q, data0_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] err_cnt_inc;

   // Saturating fault counter increment.
   assign err_cnt_inc = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_0;
         hold0_q    <= '0;
         data0_q    <= '0;
         data1_q    <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         pair_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         hold0_q    <= hold0_d;
         data0_q    <= data0_d;
         data1_q    <= data1_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         pair_cnt_q <= pair_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold0_d    = hold0_q;
      data0_d    = data0_q;
      data1_d    = data1_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      pair_cnt_d = pair_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (bus.valid_in) begin
         unique case (state_q)
            WAIT_0: begin
               if (!bus.selector_in) begin
                  hold0_d = bus.data_in;
                  state_d = WAIT_1;
               end else begin
                  err_d     = 1'b1;
                  err_cnt_d = err_cnt_inc;
               end
            end
            WAIT_1: begin
               if (bus.selector_in) begin
                  data0_d    = hold0_q;
                  data1_d    = bus.data_in;
                  valid_d    = 1'b1;
                  pair_cnt_d = pair_cnt_q + CNT_W'(1);
                  state_d    = WAIT_0;
               end else begin
                  // Second lane-0 word: newest one wins, stay waiting for lane 1.
                  hold0_d   = bus.data_in;
                  err_d     = 1'b1;
                  err_cnt_d = err_cnt_inc;
               end
            end
            default: state_d = WAIT_0;
         endcase
      end
   end

   assign bus.data_out_0  = data0_q;
   assign bus.data_out_1  = data1_q;
   assign bus.valid_out   = valid_q;
   assign bus.error_out   = err_q;
   assign bus.pair_count  = pair_cnt_q;
   assign bus.error_count = err_cnt_q;

endmodule

// File: tb/tb_demux_2x1_flop.sv
// Bench for demux_2x1_flop: directed vector table, counter-limit sequences and
// randomized stream against a lane-pairing reference model.
module tb_demux_2x1_flop;

   localparam int unsigned WIDTH = 2;
   localparam int unsigned CNT_W = 4;

   typedef struct {
      logic       rst, v, sel;
      logic [1:0] d;
      logic [1:0] e0, e1;
      logic       evo, eeo;
      logic [3:0] epc, eec;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   vec_t vecs[$];

   // Reference model state: pending lane-0 word and delivered outputs.
   bit         m_have0;
   logic [1:0] m_held, m_d0, m_d1;
   bit         m_vo, m_eo;
   int         m_pc, m_ec;

   demux_2x1_flop_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   demux_2x1_flop #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_step(input logic r, input logic v, input logic s, input logic [1:0] d);
      @(negedge clk);
      reset           = r;
      bus.valid_in    = v;
      bus.selector_in = s;
      bus.data_in     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, v, s, input logic [1:0] d, e0, e1,
                      input logic vo, eo, input logic [3:0] pc, ec);
      vec_t t;
      t.rst = r; t.v = v; t.sel = s; t.d = d;
      t.e0 = e0; t.e1 = e1; t.evo = vo; t.eeo = eo; t.epc = pc; t.eec = ec;
      vecs.push_back(t);
   endtask

   task automatic model_step(input logic r, v, s, input logic [1:0] d);
      if (r) begin
         m_have0 = 0; m_held = '0; m_d0 = '0; m_d1 = '0;
         m_vo = 0; m_eo = 0; m_pc = 0; m_ec = 0;
      end else begin
         m_vo = 0; m_eo = 0;
         if (v) begin
            if (!s) begin
               if (m_have0) begin
                  m_eo = 1;
                  m_ec = (m_ec < 15) ? m_ec + 1 : 15;
               end
               m_held  = d;
               m_have0 = 1;
            end else if (m_have0) begin
               m_d0 = m_held; m_d1 = d; m_vo = 1;
               m_pc = (m_pc + 1) % 16;
               m_have0 = 0;
            end else begin
               m_eo = 1;
               m_ec = (m_ec < 15) ? m_ec + 1 : 15;
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; bus.valid_in = 1'b0; bus.selector_in = 1'b0; bus.data_in = '0;

      // rst v sel d | d0 d1 vo eo pc ec
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,1, 0,0,0,0,0,0);
      add(0,1,1,2, 1,2,1,0,1,0);
      add(0,0,0,0, 1,2,0,0,1,0);
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,0, 0,0,0,0,0,0);
      add(0,1,1,3, 0,3,1,0,1,0);
      add(0,1,0,1, 0,3,0,0,1,0);
      add(0,1,1,2, 1,2,1,0,2,0);
      add(0,1,0,2, 1,2,0,0,2,0);
      add(0,1,1,1, 2,1,1,0,3,0);
      add(0,1,0,3, 2,1,0,0,3,0);
      add(0,1,1,0, 3,0,1,0,4,0);
      add(0,1,1,3, 3,0,0,1,4,1);
      add(0,1,0,1, 3,0,0,0,4,1);
      add(0,1,1,2, 1,2,1,0,5,1);
      add(0,1,0,1, 1,2,0,0,5,1);
      add(0,1,0,2, 1,2,0,1,5,2);
      add(0,1,1,3, 2,3,1,0,6,2);
      add(0,1,0,3, 2,3,0,0,6,2);
      add(0,0,1,1, 2,3,0,0,6,2);
      add(0,0,0,2, 2,3,0,0,6,2);
      add(0,0,1,0, 2,3,0,0,6,2);
      add(0,1,1,1, 3,1,1,0,7,2);
      add(0,1,0,2, 3,1,0,0,7,2);
      add(1,1,1,1, 0,0,0,0,0,0);
      add(0,1,1,0, 0,0,0,1,0,1);

      foreach (vecs[i]) begin
         drive_step(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].d);
         check($sformatf("vec%0d.d0", i),  int'(bus.data_out_0),  int'(vecs[i].e0));
         check($sformatf("vec%0d.d1", i),  int'(bus.data_out_1),  int'(vecs[i].e1));
         check($sformatf("vec%0d.vo", i),  int'(bus.valid_out),   int'(vecs[i].evo));
         check($sformatf("vec%0d.eo", i),  int'(bus.error_out),   int'(vecs[i].eeo));
         check($sformatf("vec%0d.pc", i),  int'(bus.pair_count),  int'(vecs[i].epc));
         check($sformatf("vec%0d.ec", i),  int'(bus.error_count), int'(vecs[i].eec));
      end

      // Pair counter wraps after 16 pairs with no error raised.
      drive_step(1, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin
         drive_step(0, 1, 0, 2'(i));
         drive_step(0, 1, 1, 2'(i + 1));
         if (i == 15) check("pc_wrap_to_0", int'(bus.pair_count), 0);
      end
      check("pc_after_17", int'(bus.pair_count), 1);
      check("ec_after_17", int'(bus.error_count), 0);
      check("d0_after_17", int'(bus.data_out_0), 0);
      check("d1_after_17", int'(bus.data_out_1), 1);

      // Error counter saturates at 15 while error_out keeps pulsing.
      drive_step(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         drive_step(0, 1, 1, 2'(i));
         if (i == 14) check("ec_at_15", int'(bus.error_count), 15);
      end
      check("ec_saturated", int'(bus.error_count), 15);
      check("eo_still_pulses", int'(bus.error_out), 1);
      check("pc_no_pairs", int'(bus.pair_count), 0);

      // Randomized stream against the reference model.
      drive_step(1, 0, 0, 0);
      model_step(1, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         logic       r, v, s;
         logic [1:0] d;
         r = ($urandom_range(99) < 2);
         v = ($urandom_range(99) < 75);
         s = 1'($urandom);
         d = 2'($urandom);
         drive_step(r, v, s, d);
         model_step(r, v, s, d);
         check("rnd.d0", int'(bus.data_out_0),  int'(m_d0));
         check("rnd.d1", int'(bus.data_out_1),  int'(m_d1));
         check("rnd.vo", int'(bus.valid_out),   int'(m_vo));
         check("rnd.eo", int'(bus.error_out),   int'(m_eo));
         check("rnd.pc", int'(bus.pair_count),  m_pc);
         check("rnd.ec", int'(bus.error_count), m_ec);
         check("rnd.vo_eo_excl", int'(bus.valid_out & bus.error_out), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
